// File: rtl/stopwatch_clock_core.sv
// Stopwatch and time-of-day core with a six-digit 7-segment display.
// A prescaler turns DIV clk cycles into one 10 ms tick. Time of day runs
// continuously; the stopwatch has IDLE/RUN/PAUSE states and, with the
// SWC_LAP_EN macro defined, an extra LAP state that freezes the display
// while counting goes on underneath.
module stopwatch_clock_core #(
    parameter int unsigned DIV = 1000000,
    parameter bit          H24 = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mode,
    input  logic        btn_ss,
    input  logic        btn_lap,
    input  logic        btn_clr,
    input  logic        inc_min,
    input  logic        inc_hour,
    output logic [41:0] seg,
    output logic        running
);

    localparam int unsigned PW       = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [4:0]  HOUR_RST = H24 ? 5'd0 : 5'd12;

    typedef struct packed {
        logic [6:0] mm;
        logic [5:0] ss;
        logic [6:0] cc;
    } sw_time_t;

`ifdef SWC_LAP_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP} sw_state_e;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE} sw_state_e;
`endif

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Two decimal digits (tens, units) of a 0..99 value.
    function automatic logic [13:0] seg_pair(input logic [6:0] v);
        return {seg7(4'(v / 7'd10)), seg7(4'(v % 7'd10))};
    endfunction

    function automatic logic [4:0] hour_next(input logic [4:0] h);
        if (H24) return (h == 5'd23) ? 5'd0 : h + 5'd1;
        else     return (h == 5'd12) ? 5'd1 : h + 5'd1;
    endfunction

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;
    logic [6:0]    tod_cs_q, tod_cs_d;
    logic [5:0]    tod_s_q, tod_s_d, tod_m_q, tod_m_d;
    logic [4:0]    tod_h_q, tod_h_d;
    logic          sec_carry, min_carry, hour_carry;
    sw_state_e     state_q, state_d;
    sw_time_t      sw_q, sw_d, disp_sw;
    logic [41:0]   seg_q, seg_d;
    logic          show_rst_q;

    // Prescaler terminal count and time-of-day ripple, set pulses overriding carries.
    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        tick       = (pre_q == PRE_LAST);
        pre_d      = tick ? '0 : pre_q + 1'b1;
        tod_cs_d   = tod_cs_q;
        tod_s_d    = tod_s_q;
        tod_m_d    = tod_m_q;
        tod_h_d    = tod_h_q;
        sec_carry  = 1'b0;
        min_carry  = 1'b0;
        hour_carry = 1'b0;
        if (tick) begin
            if (tod_cs_q == 7'd99) begin
                tod_cs_d  = '0;
                sec_carry = 1'b1;
            end else begin
                tod_cs_d = tod_cs_q + 7'd1;
            end
        end
        if (sec_carry) begin
            if (tod_s_q == 6'd59) begin
                tod_s_d   = '0;
                min_carry = 1'b1;
            end else begin
                tod_s_d = tod_s_q + 6'd1;
            end
        end
        if (inc_min) begin
            tod_m_d = (tod_m_q == 6'd59) ? 6'd0 : tod_m_q + 6'd1;
        end else if (min_carry) begin
            if (tod_m_q == 6'd59) begin
                tod_m_d    = '0;
                hour_carry = 1'b1;
            end else begin
                tod_m_d = tod_m_q + 6'd1;
            end
        end
        if (inc_hour || hour_carry) tod_h_d = hour_next(tod_h_q);
    end

    // Prescaler and time-of-day registers.
    // NOTE: sequential state uses <= so every flop samples pre-edge values together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q    <= '0;
            tod_cs_q <= '0;
            tod_s_q  <= '0;
            tod_m_q  <= '0;
            tod_h_q  <= HOUR_RST;
        end else begin
            pre_q    <= pre_d;
            tod_cs_q <= tod_cs_d;
            tod_s_q  <= tod_s_d;
            tod_m_q  <= tod_m_d;
            tod_h_q  <= tod_h_d;
        end
    end

    // Stopwatch next state: clear beats start/stop, which beats lap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (btn_ss) state_d = ST_RUN;
            ST_RUN: begin
                if (btn_ss) state_d = ST_PAUSE;
`ifdef SWC_LAP_EN
                else if (btn_lap) state_d = ST_LAP;
`endif
            end
            ST_PAUSE: if (btn_ss) state_d = ST_RUN;
`ifdef SWC_LAP_EN
            ST_LAP: begin
                if (btn_ss)       state_d = ST_PAUSE;
                else if (btn_lap) state_d = ST_RUN;
            end
`endif
            default:  state_d = ST_IDLE;
        endcase
        if (btn_clr) state_d = ST_IDLE;
    end

`ifdef SWC_LAP_EN
    assign running = (state_q == ST_RUN) || (state_q == ST_LAP);
`else
    assign running = (state_q == ST_RUN);
    logic lap_unused;
    assign lap_unused = btn_lap;
`endif

    // Stopwatch counters advance on tick only while running; 99:59.99 wraps to zero.
    always_comb begin
        sw_d = sw_q;
        if (btn_clr) begin
            sw_d = '0;
        end else if (running && tick) begin
            if (sw_q.cc == 7'd99) begin
                sw_d.cc = '0;
                if (sw_q.ss == 6'd59) begin
                    sw_d.ss = '0;
                    sw_d.mm = (sw_q.mm == 7'd99) ? 7'd0 : sw_q.mm + 7'd1;
                end else begin
                    sw_d.ss = sw_q.ss + 6'd1;
                end
            end else begin
                sw_d.cc = sw_q.cc + 7'd1;
            end
        end
    end

    // Stopwatch state register and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sw_q    <= '0;
        end else begin
            state_q <= state_d;
            sw_q    <= sw_d;
        end
    end

`ifdef SWC_LAP_EN
    sw_time_t lap_q, lap_d;

    // Lap hold captures the pre-edge count on entry to LAP.
    always_comb begin
        lap_d = lap_q;
        if (state_q == ST_RUN && state_d == ST_LAP) lap_d = sw_q;
    end

    // Lap hold register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lap_q <= '0;
        else        lap_q <= lap_d;
    end
`endif

    // Digit encoding for the selected display source.
    always_comb begin
        disp_sw = sw_q;
`ifdef SWC_LAP_EN
        if (state_q == ST_LAP) disp_sw = lap_q;
`endif
        if (mode) seg_d = {seg_pair(disp_sw.mm), seg_pair({1'b0, disp_sw.ss}),
                           seg_pair(disp_sw.cc)};
        else      seg_d = {seg_pair({2'b00, tod_h_q}), seg_pair({1'b0, tod_m_q}),
                           seg_pair({1'b0, tod_s_q})};
    end

    // Registered display; until the first edge after reset the encoding of the
    // reset state is passed straight through so it follows mode during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q      <= '0;
            show_rst_q <= 1'b1;
        end else begin
            seg_q      <= seg_d;
            show_rst_q <= 1'b0;
        end
    end

    assign seg = show_rst_q ? seg_d : seg_q;

endmodule
